// File: rtl/io_buf_pkg.sv
// Shared definitions for the io_buffer arbiter: op encoding and width helpers.
package io_buf_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    localparam int STALL_W = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int id_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

endpackage

// File: rtl/io_buffer_arbiter_if.sv
// Requester handshake plus LIFO buffer command/return bus for io_buffer_arbiter.
interface io_buffer_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int STACK_SIZE = 256,
    parameter int NUM_REQ    = 2
);
    import io_buf_pkg::*;

    localparam int CNT_W = clog2(STACK_SIZE + 1);
    localparam int ID_W  = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ-1:0]            i_req_pop;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic                          o_buf_push;
    logic                          o_buf_pop;
    logic [DATA_WIDTH-1:0]         o_buf_data;
    logic [DATA_WIDTH-1:0]         i_buf_data;
    logic                          o_rd_valid;
    logic [ID_W-1:0]               o_rd_id;
    logic [DATA_WIDTH-1:0]         o_rd_data;
    logic [CNT_W-1:0]              o_count;
    logic                          o_full;
    logic                          o_empty;

    modport master (
        output i_req_valid, i_req_pop, i_req_data, i_buf_data,
        input  o_req_ready, o_buf_push, o_buf_pop, o_buf_data,
               o_rd_valid, o_rd_id, o_rd_data, o_count, o_full, o_empty
    );

    modport slave (
        input  i_req_valid, i_req_pop, i_req_data, i_buf_data,
        output o_req_ready, o_buf_push, o_buf_pop, o_buf_data,
               o_rd_valid, o_rd_id, o_rd_data, o_count, o_full, o_empty
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating pointer holds the last granted index.
module rr_arbiter
    import io_buf_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx
);
    localparam int SUM_W = ID_W + 1;

    logic [ID_W-1:0] ptr_q, ptr_d;

    // Scan from the index after the last grant, wrapping, first eligible wins
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [ID_W-1:0]  idx;
        logic             found;
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            sum = SUM_W'(ptr_q) + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && i_eligible[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_idx  = idx;
            end
        end
    end

    // Pointer follows the grant only when the transfer is accepted
    always_comb begin
        ptr_d = i_advance ? o_grant_idx : ptr_q;
    end

    // Pointer register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/io_buffer_arbiter.sv
// Shares one LIFO io_buffer between NUM_REQ requesters with round-robin access.
// Optional statistics ports are enabled by defining IO_BUF_ARB_STATS_EN.
// The enclosing system ties the buffer's i_rst_n to ~i_rst so both clear together.
module io_buffer_arbiter
    import io_buf_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int STACK_SIZE = 256,
    parameter  int NUM_REQ    = 2,
    localparam int CNT_W      = clog2(STACK_SIZE + 1),
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input logic                i_clk,
    input logic                i_rst,
    io_buffer_arbiter_if.slave bus
`ifdef IO_BUF_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   o_high_water,
    output logic [STALL_W-1:0] o_stall_cnt
`endif
);
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    op_e                   sel_op;
    logic                  full, empty;

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  buf_push_q, buf_push_d;
    logic                  buf_pop_q, buf_pop_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [ID_W-1:0]       cmd_id_q, cmd_id_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ID_W-1:0]       rd_id_q, rd_id_d;

    assign full  = (count_q == CNT_W'(STACK_SIZE));
    assign empty = (count_q == '0);

    // A request is eligible only if its op cannot over- or underflow the stack
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (op_e'(bus.i_req_pop[k]) == OP_POP) begin
                eligible[k] = bus.i_req_valid[k] & ~empty;
            end else begin
                eligible[k] = bus.i_req_valid[k] & ~full;
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_eligible  (eligible),
        .i_advance   (accept),
        .o_grant     (grant),
        .o_grant_idx (grant_idx)
    );

    // Ready is one-hot over eligible requests, so any grant is an accepted transfer
    assign accept = |grant;

    // Select the granted requester's op and push data
    always_comb begin
        sel_data = '0;
        sel_op   = OP_PUSH;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_data = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_op   = op_e'(bus.i_req_pop[k]);
            end
        end
    end

    // Occupancy, command stage and pop-return pipeline next state
    always_comb begin
        count_d    = count_q;
        buf_push_d = 1'b0;
        buf_pop_d  = 1'b0;
        buf_data_d = buf_data_q;
        cmd_id_d   = cmd_id_q;
        rd_valid_d = buf_pop_q;
        rd_id_d    = buf_pop_q ? cmd_id_q : rd_id_q;
        if (accept) begin
            cmd_id_d = grant_idx;
            if (sel_op == OP_POP) begin
                buf_pop_d = 1'b1;
                count_d   = count_q - CNT_W'(1);
            end else begin
                buf_push_d = 1'b1;
                buf_data_d = sel_data;
                count_d    = count_q + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q    <= '0;
            buf_push_q <= 1'b0;
            buf_pop_q  <= 1'b0;
            buf_data_q <= '0;
            cmd_id_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
        end else begin
            count_q    <= count_d;
            buf_push_q <= buf_push_d;
            buf_pop_q  <= buf_pop_d;
            buf_data_q <= buf_data_d;
            cmd_id_q   <= cmd_id_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign bus.o_req_ready = grant;
    assign bus.o_buf_push  = buf_push_q;
    assign bus.o_buf_pop   = buf_pop_q;
    assign bus.o_buf_data  = buf_data_q;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_rd_id     = rd_id_q;
    assign bus.o_rd_data   = bus.i_buf_data;
    assign bus.o_count     = count_q;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;

`ifdef IO_BUF_ARB_STATS_EN
    logic [CNT_W-1:0]   high_water_q, high_water_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    // High-water mark trails the count by one cycle; stall counter saturates
    always_comb begin
        high_water_d = (count_q > high_water_q) ? count_q : high_water_q;
        stall_cnt_d  = stall_cnt_q;
        if ((|bus.i_req_valid) && !(|eligible) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // Statistics registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            high_water_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            high_water_q <= high_water_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign o_high_water = high_water_q;
    assign o_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_io_buffer_arbiter.sv
// Self-checking bench for io_buffer_arbiter with a behavioural LIFO buffer.
module tb_io_buffer_arbiter;
    import io_buf_pkg::*;

    localparam int DW    = 16;
    localparam int SS    = 256;
    localparam int NR    = 2;
    localparam int CNT_W = clog2(SS + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    io_buffer_arbiter_if #(.DATA_WIDTH(DW), .STACK_SIZE(SS), .NUM_REQ(NR)) bus ();

`ifdef IO_BUF_ARB_STATS_EN
    logic [CNT_W-1:0] hw;
    logic [15:0]      stall;
`endif

    io_buffer_arbiter #(
        .DATA_WIDTH (DW),
        .STACK_SIZE (SS),
        .NUM_REQ    (NR)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef IO_BUF_ARB_STATS_EN
        ,
        .o_high_water (hw),
        .o_stall_cnt  (stall)
`endif
    );

    // Behavioural stack: executes the registered command, output registered on pop
    logic [DW-1:0] mem [SS];
    int            sp;
    logic [DW-1:0] buf_q;
    assign bus.i_buf_data = buf_q;

    always @(posedge clk) begin
        if (rst) begin
            sp    <= 0;
            buf_q <= '0;
        end else if (bus.o_buf_push) begin
            if (sp < SS) begin
                mem[sp[7:0]] <= bus.o_buf_data;
                sp           <= sp + 1;
            end
        end else if (bus.o_buf_pop) begin
            if (sp > 0) begin
                buf_q <= mem[8'(sp - 1)];
                sp    <= sp - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  pop;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  ready;
        logic [8:0]  count;
        logic        push_o;
        logic        pop_o;
        logic [15:0] bdata;
        logic        rdv;
        logic        rdid;
        logic [15:0] rdd;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        //           valid  pop    d0        d1        ready  cnt   push  pop   bdata     rdv   rdid  rdd
        vecs[0]  = '{2'b01, 2'b00, 16'h1111, 16'h0000, 2'b01, 9'd1, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{2'b01, 2'b00, 16'h2222, 16'h0000, 2'b01, 9'd2, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{2'b01, 2'b01, 16'h2222, 16'h0000, 2'b01, 9'd1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{2'b01, 2'b01, 16'h2222, 16'h0000, 2'b01, 9'd0, 1'b0, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h2222};
        vecs[4]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 9'd0, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b0, 16'h1111};
        vecs[5]  = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 9'd0, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{2'b11, 2'b00, 16'hA000, 16'hB000, 2'b10, 9'd1, 1'b1, 1'b0, 16'hB000, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{2'b11, 2'b00, 16'hA000, 16'hB001, 2'b01, 9'd2, 1'b1, 1'b0, 16'hA000, 1'b0, 1'b0, 16'h0000};
        vecs[8]  = '{2'b11, 2'b00, 16'hA001, 16'hB001, 2'b10, 9'd3, 1'b1, 1'b0, 16'hB001, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{2'b11, 2'b00, 16'hA001, 16'hB002, 2'b01, 9'd4, 1'b1, 1'b0, 16'hA001, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{2'b10, 2'b10, 16'h0000, 16'h0000, 2'b10, 9'd3, 1'b0, 1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{2'b10, 2'b10, 16'h0000, 16'h0000, 2'b10, 9'd2, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b1, 16'hA001};
        vecs[12] = '{2'b10, 2'b10, 16'h0000, 16'h0000, 2'b10, 9'd1, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b1, 16'hB001};
        vecs[13] = '{2'b10, 2'b10, 16'h0000, 16'h0000, 2'b10, 9'd0, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b1, 16'hA000};
        vecs[14] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 9'd0, 1'b0, 1'b0, 16'hA001, 1'b1, 1'b1, 16'hB000};
        vecs[15] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 9'd0, 1'b0, 1'b0, 16'hA001, 1'b0, 1'b0, 16'h0000};
        vecs[16] = '{2'b11, 2'b01, 16'h0000, 16'hC0DE, 2'b10, 9'd1, 1'b1, 1'b0, 16'hC0DE, 1'b0, 1'b0, 16'h0000};
        vecs[17] = '{2'b01, 2'b01, 16'h0000, 16'h0000, 2'b01, 9'd0, 1'b0, 1'b1, 16'hC0DE, 1'b0, 1'b0, 16'h0000};
        vecs[18] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 9'd0, 1'b0, 1'b0, 16'hC0DE, 1'b1, 1'b0, 16'hC0DE};
        vecs[19] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 9'd0, 1'b0, 1'b0, 16'hC0DE, 1'b0, 1'b0, 16'h0000};

        rst             = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_pop   = '0;
        bus.i_req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push",  32'(bus.o_buf_push), 32'd0);
        chk("rst_pop",   32'(bus.o_buf_pop),  32'd0);
        chk("rst_bdata", 32'(bus.o_buf_data), 32'd0);
        chk("rst_rdv",   32'(bus.o_rd_valid), 32'd0);
        chk("rst_rdid",  32'(bus.o_rd_id),    32'd0);
        chk("rst_count", 32'(bus.o_count),    32'd0);
        chk("rst_empty", 32'(bus.o_empty),    32'd1);
        chk("rst_full",  32'(bus.o_full),     32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            bus.i_req_valid = vecs[i].valid;
            bus.i_req_pop   = vecs[i].pop;
            bus.i_req_data  = {vecs[i].d1, vecs[i].d0};
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.o_req_ready), 32'(vecs[i].ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_count", i), 32'(bus.o_count),    32'(vecs[i].count));
            chk($sformatf("v%0d_push", i),  32'(bus.o_buf_push), 32'(vecs[i].push_o));
            chk($sformatf("v%0d_pop", i),   32'(bus.o_buf_pop),  32'(vecs[i].pop_o));
            chk($sformatf("v%0d_bdata", i), 32'(bus.o_buf_data), 32'(vecs[i].bdata));
            chk($sformatf("v%0d_rdv", i),   32'(bus.o_rd_valid), 32'(vecs[i].rdv));
            chk($sformatf("v%0d_empty", i), 32'(bus.o_empty),    32'(vecs[i].count == 9'd0));
            chk($sformatf("v%0d_full", i),  32'(bus.o_full),     32'(vecs[i].count == 9'd256));
            if (vecs[i].rdv) begin
                chk($sformatf("v%0d_rdid", i), 32'(bus.o_rd_id),   32'(vecs[i].rdid));
                chk($sformatf("v%0d_rdd", i),  32'(bus.o_rd_data), 32'(vecs[i].rdd));
            end
            @(negedge clk);
        end

        // Fill to capacity from requester 0
        bus.i_req_pop   = 2'b00;
        bus.i_req_valid = 2'b01;
        for (int i = 0; i < SS; i++) begin
            d              = 16'h1000 + 16'(i);
            bus.i_req_data = {16'h0000, d};
            #1;
            chk("fill_ready", 32'(bus.o_req_ready), 32'h1);
            if (i == SS - 1) begin
                chk("fill_cnt_255",   32'(bus.o_count), 32'd255);
                chk("fill_full_pre",  32'(bus.o_full),  32'd0);
            end
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        chk("fill_count", 32'(bus.o_count), 32'd256);
        chk("fill_full",  32'(bus.o_full),  32'd1);
        chk("fill_empty", 32'(bus.o_empty), 32'd0);

        // Push from requester 1 while full must stall
        bus.i_req_valid = 2'b10;
        bus.i_req_data  = {16'hBEEF, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_ready", 32'(bus.o_req_ready), 32'h0);
            @(posedge clk);
            #1;
            chk("full_push", 32'(bus.o_buf_push), 32'd0);
            @(negedge clk);
        end
`ifdef IO_BUF_ARB_STATS_EN
        chk("stat_stall", 32'(stall), 32'd5);
        chk("stat_hw",    32'(hw),    32'd256);
`endif

        // Requester 0 pops, then requester 1's push goes through
        bus.i_req_valid = 2'b11;
        bus.i_req_pop   = 2'b01;
        #1;
        chk("unfull_ready0", 32'(bus.o_req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("unfull_count", 32'(bus.o_count),   32'd255);
        chk("unfull_pop",   32'(bus.o_buf_pop), 32'd1);
        chk("unfull_full",  32'(bus.o_full),    32'd0);
        @(negedge clk);
        bus.i_req_valid = 2'b10;
        bus.i_req_pop   = 2'b00;
        #1;
        chk("unfull_ready1", 32'(bus.o_req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("refill_count", 32'(bus.o_count),    32'd256);
        chk("refill_push",  32'(bus.o_buf_push), 32'd1);
        chk("refill_bdata", 32'(bus.o_buf_data), 32'hBEEF);
        chk("refill_rdv",   32'(bus.o_rd_valid), 32'd1);
        chk("refill_rdid",  32'(bus.o_rd_id),    32'd0);
        chk("refill_rdd",   32'(bus.o_rd_data),  32'h10FF);
        @(negedge clk);

        // Reset while a pop from requester 1 is in flight
        bus.i_req_valid = 2'b10;
        bus.i_req_pop   = 2'b10;
        #1;
        chk("inflt_ready", 32'(bus.o_req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("inflt_pop",   32'(bus.o_buf_pop), 32'd1);
        chk("inflt_count", 32'(bus.o_count),   32'd255);
        @(negedge clk);
        rst             = 1'b1;
        bus.i_req_valid = 2'b00;
        bus.i_req_pop   = 2'b00;
        @(posedge clk);
        #1;
        chk("mrst_rdv",   32'(bus.o_rd_valid), 32'd0);
        chk("mrst_count", 32'(bus.o_count),    32'd0);
        chk("mrst_pop",   32'(bus.o_buf_pop),  32'd0);
        chk("mrst_push",  32'(bus.o_buf_push), 32'd0);
        chk("mrst_bdata", 32'(bus.o_buf_data), 32'd0);
        chk("mrst_empty", 32'(bus.o_empty),    32'd1);
`ifdef IO_BUF_ARB_STATS_EN
        chk("mrst_hw",    32'(hw),    32'd0);
        chk("mrst_stall", 32'(stall), 32'd0);
`endif
        @(negedge clk);
        rst             = 1'b0;
        bus.i_req_valid = 2'b11;
        bus.i_req_data  = {16'h6666, 16'h5555};
        #1;
        chk("post_rst_ready", 32'(bus.o_req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("post_rst_bdata", 32'(bus.o_buf_data), 32'h6666);
        chk("post_rst_count", 32'(bus.o_count),    32'd1);
        @(negedge clk);
        bus.i_req_valid = 2'b00;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_buffer_arbiter.md
Name: io_buffer_arbiter

Overview:
Shares one LIFO io_buffer (push/pop stack) between NUM_REQ requesters, e.g. matrix operand loaders and result writers.
- Round-robin arbitration; at most one stack op per cycle.
- Tracks occupancy and blocks pushes when full and pops when empty, so the buffer never over- or underflows.
- Drives the buffer's push/pop/data inputs, returns pop data tagged with the requester ID.

Parameters:
- DATA_WIDTH, 16, word width; must match the buffer.
- STACK_SIZE, 256, buffer depth in words.
- NUM_REQ, 2, number of requesters, at least 2.
- CNT_W (local), clog2(STACK_SIZE+1), occupancy width.
- ID_W (local), max(1, clog2(NUM_REQ)), requester ID width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  NUM_REQ  per-requester op request
- i_req_pop  in  NUM_REQ  per-requester op select: 1 = pop, 0 = push
- i_req_data  in  NUM_REQ*DATA_WIDTH  push data; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_req_ready  out  NUM_REQ  one-hot or zero, combinational; transfer when valid & ready at the edge
- o_buf_push  out  1  to buffer i_push_cmd, registered
- o_buf_pop  out  1  to buffer i_pop_cmd, registered
- o_buf_data  out  DATA_WIDTH  to buffer i_data, registered
- i_buf_data  in  DATA_WIDTH  from buffer o_data
- o_rd_valid  out  1  pop data valid, one-cycle pulse
- o_rd_id  out  ID_W  requester that issued the returned pop
- o_rd_data  out  DATA_WIDTH  pop data; passthrough of i_buf_data
- o_count  out  CNT_W  current occupancy
- o_full  out  1  o_count == STACK_SIZE
- o_empty  out  1  o_count == 0

Behaviour:
- Reset (i_rst=1 at an edge): o_buf_push=0, o_buf_pop=0, o_buf_data=0, o_rd_valid=0, o_rd_id=0, o_count=0, RR pointer=0.
  - Reset mid-operation drops in-flight ops.
  - The top level ties the buffer's i_rst_n = ~i_rst so the stack clears in the same cycle.
- Eligibility: requester k is eligible iff i_req_valid[k] and one of:
  - push (i_req_pop[k]=0) with !o_full, or
  - pop (i_req_pop[k]=1) with !o_empty.
- Arbitration: scan starts at the index after the last granted requester and wraps. The first eligible requester gets o_req_ready. All others see ready=0 and must hold valid and data stable.
- RR pointer moves to the granted index only on an accepted transfer.
- Ineligible requests (push when full, pop when empty) wait without error. A full stack with only push requests stalls until a pop is accepted.
- Accept at edge T:
  - o_count updates at T: +1 for push, -1 for pop.
  - During cycle T: o_buf_push or o_buf_pop = 1, o_buf_data = the granted requester's data (push only; otherwise it holds its last value).
  - Buffer performs the op at edge T+1.
- Pop return:
  - o_rd_valid=1 and o_rd_id = granted index during cycle T+1.
  - o_rd_data = i_buf_data, valid in that cycle.
  - Latency is 2 edges from acceptance; throughput is one op per cycle, so back-to-back pops yield consecutive o_rd_valid pulses.
- Ordering: LIFO across all requesters. A pop returns the most recent unpopped push regardless of which requester pushed it.
- Idle cycles: o_buf_push, o_buf_pop and o_rd_valid are all 0. Push and pop are never asserted together.
- Flag timing: o_full and o_empty derive from the registered o_count.
  - With o_count = STACK_SIZE-1, an accepted push makes o_full=1 in the next cycle and blocks pushes from then on.
  - With o_count = 1, an accepted pop makes o_empty=1 in the next cycle and blocks pops from then on.

Optional Feature:
IO_BUF_ARB_STATS_EN
- Defined: adds o_high_water (CNT_W), the maximum o_count since reset, updated the cycle after o_count rises. Also adds o_stall_cnt (16 bits, saturating), incremented every cycle in which some i_req_valid=1 but no requester is eligible. Both clear on reset.
- Undefined: neither port nor its logic exists.

Decomposition:
- Package io_buf_pkg: op encoding (OP_PUSH=0, OP_POP=1), and functions clog2 and id_width used for CNT_W and ID_W.
- Sub-module rr_arbiter (NUM_REQ): inputs eligible vector and an advance strobe; outputs a one-hot grant and the granted index. It holds the rotating pointer.
- io_buffer_arbiter contains the occupancy counter, the command register stage and the return pipeline.

Test Plan:
- Reset, then requester 0 pushes 0x1111, 0x2222, then pops twice -> o_rd_data 0x2222 then 0x1111, o_rd_id=0 each time; o_count 0,1,2,1,0; o_empty=1 at the end.
- Both requesters continuously push (req0 0xA000+n, req1 0xB000+n) -> grants alternate 0,1,0,1; o_buf_data alternates sources; no cycle has both ready bits high.
- Fill to STACK_SIZE=256 -> o_full=1; a further push from req1 sees ready=0 indefinitely; req0 then pops -> it returns the last pushed word, o_full drops, and req1's push is accepted next.
- Pop at o_empty=1 -> ready held at 0 and o_buf_pop never asserts; a concurrent push from the other requester is granted, and the pop is accepted in the following cycle, returning the pushed word.
- Back-to-back pops from req1 over 4 cycles -> o_rd_valid high 4 consecutive cycles, each 2 edges after its acceptance, o_rd_id=1.
- Assert i_rst for one cycle while a pop is in flight -> o_rd_valid=0 the next cycle and o_count=0. With IO_BUF_ARB_STATS_EN defined, o_high_water=0 and o_stall_cnt=0.
